// File: rtl/nicnac16_pkg.sv
// Shared NICNAC16 constants and types used by the fetch stage and its neighbours.
package nicnac16_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;

    // Opcodes live in INSTR[15:12]
    localparam logic [OP_W-1:0] NOP_OP = 4'h0;
    localparam logic [OP_W-1:0] JMP_OP = 4'h9;
    localparam logic [OP_W-1:0] HLT_OP = 4'hF;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2
    } fetch_state_t;

endpackage : nicnac16_pkg

// File: rtl/fetch_unit.sv
// NICNAC16 instruction fetch: owns the PC, drives the ROM address and buffers one
// instruction for decode over a valid/ready handshake, with jump redirect and HLT stop.
module fetch_unit #(
    parameter int unsigned     ADDR_W   = nicnac16_pkg::ADDR_W,
    parameter int unsigned     DATA_W   = nicnac16_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HLT_OP   = nicnac16_pkg::HLT_OP
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [DATA_W-1:0] ROM_DATA,
    input  logic              JUMP,
    input  logic [ADDR_W-1:0] JUMP_TARGET,
    output logic [DATA_W-1:0] INSTR,
    output logic [ADDR_W-1:0] INSTR_PC,
    output logic              INSTR_VALID,
    input  logic              INSTR_READY,
    output logic [ADDR_W-1:0] PC,
    output logic              HALTED
);

    import nicnac16_pkg::*;

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [DATA_W-1:0]   r_instr;
    logic [DATA_W-1:0]   w_instr_nxt;
    logic [ADDR_W-1:0]   r_instr_pc;
    logic [ADDR_W-1:0]   w_instr_pc_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic                r_halted;
    logic                w_free;
    logic                w_load;
    logic                w_is_hlt;

    // Buffer can take a new word when empty or being drained this cycle
    assign w_free   = !r_valid || INSTR_READY;
    assign w_load   = (r_state == ST_RUN) && w_free && !JUMP;
    assign w_is_hlt = (ROM_DATA[DATA_W-1 -: 4] == HLT_OP);

    // Next-state, PC and buffer update; a jump overrides any load and flushes the buffer
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;

        case (r_state)
            ST_STOPPED,
            ST_HALTED: begin
                if (START) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_load && w_is_hlt) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            default: begin
                w_state_nxt = ST_STOPPED;
            end
        endcase

        if (r_valid && INSTR_READY) begin
            w_valid_nxt = 1'b0;
        end

        if (JUMP) begin
            w_pc_nxt    = JUMP_TARGET;
            w_valid_nxt = 1'b0;
        end else if (w_load) begin
            w_instr_nxt    = ROM_DATA;
            w_instr_pc_nxt = r_pc;
            w_valid_nxt    = 1'b1;
            w_pc_nxt       = r_pc + ADDR_W'(1);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_STOPPED;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_halted   <= (w_state_nxt == ST_HALTED);
        end
    end

    assign ROM_ADDR    = r_pc;
    assign PC          = r_pc;
    assign INSTR       = r_instr;
    assign INSTR_PC    = r_instr_pc;
    assign INSTR_VALID = r_valid;
    assign HALTED      = r_halted;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table of per-cycle stimulus and expected
// outputs, followed by hand-written latency and halt-hold sequences.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [7:0]  ROM_ADDR;
    logic [15:0] ROM_DATA;
    logic        JUMP;
    logic [7:0]  JUMP_TARGET;
    logic [15:0] INSTR;
    logic [7:0]  INSTR_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [7:0]  PC;
    logic        HALTED;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rom [256];

    typedef struct {
        logic        rst;
        logic        start;
        logic        jump;
        logic [7:0]  tgt;
        logic        ready;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [7:0]  e_ipc;
        logic [7:0]  e_pc;
        logic        e_halted;
    } vec_t;

    vec_t vecs[$];

    fetch_unit dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .ROM_ADDR    (ROM_ADDR),
        .ROM_DATA    (ROM_DATA),
        .JUMP        (JUMP),
        .JUMP_TARGET (JUMP_TARGET),
        .INSTR       (INSTR),
        .INSTR_PC    (INSTR_PC),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .PC          (PC),
        .HALTED      (HALTED)
    );

    always #5 CLK = ~CLK;

    // Combinational program ROM
    assign ROM_DATA = rom[ROM_ADDR];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs for one cycle, then sample just after the rising edge
    task automatic step(input logic rst, input logic start, input logic jump,
                        input logic [7:0] tgt, input logic ready);
        RESET       = rst;
        START       = start;
        JUMP        = jump;
        JUMP_TARGET = tgt;
        INSTR_READY = ready;
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic rst, input logic start, input logic jump,
                       input logic [7:0] tgt, input logic ready,
                       input logic e_valid, input logic [15:0] e_instr,
                       input logic [7:0] e_ipc, input logic [7:0] e_pc,
                       input logic e_halted);
        vec_t v;
        v.rst = rst; v.start = start; v.jump = jump; v.tgt = tgt; v.ready = ready;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_ipc = e_ipc;
        v.e_pc = e_pc; v.e_halted = e_halted;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
        rom[0]   = 16'h1234;
        rom[1]   = 16'h5678;
        rom[2]   = 16'hF000;
        rom[3]   = 16'h9ABC;
        rom[255] = 16'h4321;

        //   rst st jmp tgt    rdy   v  instr     ipc    pc     h
        add(0, 1, 0, 8'd0,   1,    0, 16'h0000, 8'd0,   8'd0,   0); // START -> RUN, no word yet
        add(0, 0, 0, 8'd0,   1,    1, 16'h1234, 8'd0,   8'd1,   0);
        add(0, 0, 0, 8'd0,   1,    1, 16'h5678, 8'd1,   8'd2,   0);
        add(0, 0, 0, 8'd0,   1,    1, 16'hF000, 8'd2,   8'd3,   1); // HLT loaded, halt same edge
        add(0, 0, 0, 8'd0,   1,    0, 16'hF000, 8'd2,   8'd3,   1); // HLT consumed, no load
        add(0, 0, 0, 8'd0,   1,    0, 16'hF000, 8'd2,   8'd3,   1);
        add(0, 1, 0, 8'd0,   1,    0, 16'hF000, 8'd2,   8'd3,   0); // resume
        add(0, 0, 0, 8'd0,   1,    1, 16'h9ABC, 8'd3,   8'd4,   0);
        add(0, 0, 0, 8'd0,   1,    1, 16'h0000, 8'd4,   8'd5,   0);
        add(0, 0, 1, 8'd0,   0,    0, 16'h0000, 8'd4,   8'd0,   0); // jump flushes unconsumed word
        add(0, 0, 0, 8'd0,   0,    1, 16'h1234, 8'd0,   8'd1,   0);
        add(0, 0, 0, 8'd0,   0,    1, 16'h1234, 8'd0,   8'd1,   0); // stall x3
        add(0, 0, 0, 8'd0,   0,    1, 16'h1234, 8'd0,   8'd1,   0);
        add(0, 0, 0, 8'd0,   0,    1, 16'h1234, 8'd0,   8'd1,   0);
        add(0, 0, 0, 8'd0,   1,    1, 16'h5678, 8'd1,   8'd2,   0); // release: next word, no skip
        add(0, 0, 0, 8'd0,   0,    1, 16'h5678, 8'd1,   8'd2,   0);
        add(0, 0, 1, 8'd3,   0,    0, 16'h5678, 8'd1,   8'd3,   0); // jump to 3 over buffered 5678
        add(0, 0, 0, 8'd0,   0,    1, 16'h9ABC, 8'd3,   8'd4,   0);
        add(0, 0, 1, 8'd255, 1,    0, 16'h9ABC, 8'd3,   8'd255, 0); // handshake + jump
        add(0, 0, 0, 8'd0,   1,    1, 16'h4321, 8'd255, 8'd0,   0); // PC wraps
        add(0, 0, 0, 8'd0,   1,    1, 16'h1234, 8'd0,   8'd1,   0);
        add(0, 1, 0, 8'd0,   1,    1, 16'h5678, 8'd1,   8'd2,   0); // START in RUN ignored
        add(0, 0, 0, 8'd0,   0,    1, 16'h5678, 8'd1,   8'd2,   0); // stalled valid word
        add(1, 0, 0, 8'd0,   0,    0, 16'h0000, 8'd0,   8'd0,   0); // reset mid-run
        add(0, 0, 1, 8'd1,   1,    0, 16'h0000, 8'd0,   8'd1,   0); // jump while STOPPED
        add(0, 0, 0, 8'd0,   1,    0, 16'h0000, 8'd0,   8'd1,   0); // still no fetch
        add(0, 1, 1, 8'd2,   1,    0, 16'h0000, 8'd0,   8'd2,   0); // START+JUMP from STOPPED
        add(0, 0, 0, 8'd0,   0,    1, 16'hF000, 8'd2,   8'd3,   1);
        add(0, 1, 1, 8'd0,   0,    0, 16'hF000, 8'd2,   8'd0,   0); // START+JUMP from HALTED
        add(0, 0, 0, 8'd0,   1,    1, 16'h1234, 8'd0,   8'd1,   0);

        // Reset and check reset state
        step(1, 0, 0, 8'd0, 0);
        step(1, 0, 0, 8'd0, 0);
        chk("reset valid",  32'(INSTR_VALID), 32'd0);
        chk("reset instr",  32'(INSTR),       32'd0);
        chk("reset ipc",    32'(INSTR_PC),    32'd0);
        chk("reset pc",     32'(PC),          32'd0);
        chk("reset halted", 32'(HALTED),      32'd0);
        chk("reset romadr", 32'(ROM_ADDR),    32'd0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].jump, vecs[i].tgt, vecs[i].ready);
            chk($sformatf("row%0d valid", i),  32'(INSTR_VALID), 32'(vecs[i].e_valid));
            chk($sformatf("row%0d instr", i),  32'(INSTR),       32'(vecs[i].e_instr));
            chk($sformatf("row%0d ipc", i),    32'(INSTR_PC),    32'(vecs[i].e_ipc));
            chk($sformatf("row%0d pc", i),     32'(PC),          32'(vecs[i].e_pc));
            chk($sformatf("row%0d halted", i), 32'(HALTED),      32'(vecs[i].e_halted));
            chk($sformatf("row%0d romadr", i), 32'(ROM_ADDR),    32'(vecs[i].e_pc));
        end

        // Latency: edges after the START edge until the first valid word
        step(1, 0, 0, 8'd0, 1);
        step(0, 1, 0, 8'd0, 1);
        chk("lat valid at start edge", 32'(INSTR_VALID), 32'd0);
        k = 0;
        while (!INSTR_VALID && k < 8) begin
            step(0, 0, 0, 8'd0, 1);
            k++;
        end
        chk("lat edges to valid", 32'(k), 32'd1);
        chk("lat first instr", 32'(INSTR), 32'h1234);

        // Run into HLT, then confirm fetch stays stopped with decode always ready
        step(0, 0, 0, 8'd0, 1);
        chk("seq instr 5678", 32'(INSTR), 32'h5678);
        step(0, 0, 0, 8'd0, 1);
        chk("seq instr hlt", 32'(INSTR), 32'hF000);
        chk("seq halted", 32'(HALTED), 32'd1);
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 0, 8'd0, 1);
            chk($sformatf("hold%0d valid", c),  32'(INSTR_VALID), 32'd0);
            chk($sformatf("hold%0d pc", c),     32'(PC),          32'd3);
            chk($sformatf("hold%0d halted", c), 32'(HALTED),      32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
